decoder_rom_arbiter: RTL and testbench
======================================

// Module: decoder_rom_arbiter
// PURPOSE
//  Shares one 512x8 synchronous decoder ROM between several requesters. The ROM has
//  one-cycle registered read latency and a clock enable. Requesters present an address
//  with a valid/ready handshake. The block grants one request per cycle, round-robin,
//  drives the ROM port, and returns the data with a per-requester response strobe.
//  It sits between the video/address-decode consumers and the decoder ROM instance.
// PARAMETERS
//  REQUESTERS  4  number of requesters, 2..8
//  ADDR_W      9  ROM address width
//  DATA_W      8  ROM data width
// PORTS
//  clock_i             in   1                  system clock, all logic on posedge
//  reset_n_i           in   1                  asynchronous reset, active-low
//  pause_i             in   1                  1 = issue no new grants; in-flight reads complete
//  req_valid_i         in   REQUESTERS         request k has an address pending
//  req_addr_i          in   REQUESTERS*ADDR_W  address k at [k*ADDR_W +: ADDR_W]
//  req_ready_o         out  REQUESTERS         one-hot grant; handshake completes on valid&ready
//  rsp_valid_o         out  REQUESTERS         one-hot, one-cycle strobe: rsp_data_o belongs to k
//  rsp_data_o          out  DATA_W             registered ROM data, shared by all requesters
//  rom_clock_enable_o  out  1                  ROM clock enable, high only in grant cycles
//  rom_address_o       out  ADDR_W             ROM address, equals the granted req_addr
//  rom_data_i          in   DATA_W             ROM output, valid the cycle after enable
// BEHAVIOUR
//  - Reset values: rsp_valid_o=0, rsp_data_o=0, pointer=0, pipeline tags cleared.
//    req_ready_o=0 and rom_clock_enable_o=0 while reset_n_i is low.
//  - Grant logic is combinational. req_ready_o[k]=1 when k is the first valid requester
//    at or after the pointer (modulo REQUESTERS) and pause_i=0. No valid requester or
//    pause_i=1 gives all-zero grant.
//  - rom_clock_enable_o = |req_ready_o. rom_address_o = address of the granted requester.
//    With no grant, rom_address_o=0 and the ROM output holds.
//  - Pointer: after a grant to k it becomes (k+1) mod REQUESTERS. With no grant it holds.
//  - Pipeline: grant in cycle t; rom_data_i is valid in t+1; rsp_data_o is registered
//    and rsp_valid_o[k] pulses in t+2. Fixed latency is 2 cycles.
//  - Throughput is one grant per cycle. Back-to-back grants give back-to-back responses
//    in grant order.
//  - rsp_data_o holds its last value when rsp_valid_o=0.
//  - Requester contract: req_addr must stay stable while valid=1 and ready=0, and valid
//    must not drop before ready. The block does not check this. A requester may
//    re-request in the cycle after its grant.
//  - pause_i rising with reads in flight: stage t+1 and stage t+2 still deliver.
//  - Async reset mid-operation: in-flight tags are cleared and their responses are
//    never strobed. Requesters re-issue after reset.
//  - Unused upper pointer codes (REQUESTERS not a power of 2) never occur. Pointer
//    arithmetic wraps explicitly at REQUESTERS-1.
// STRUCTURE
//  - Shared package decoder_rom_pkg: DECODER_ROM_ADDR_W=9, DECODER_ROM_DATA_W=8, and the
//    one-cycle ROM latency constant.
//  - Sub-module rr_arbiter(N): request vector and pointer in, one-hot grant and
//    next-pointer out. Combinational core; the pointer register stays in the parent.
//  - Parent holds the pointer, a two-stage one-hot tag pipeline, the response data
//    register and the address mux.
// TESTING
//  1 Reset: hold reset_n_i=0 with all req_valid=1 -> ready=0, rom_clock_enable_o=0,
//    rsp_valid_o=0, rsp_data_o=0.
//  2 Single read: req 2 valid, addr 9'h1A5, ROM model mem[1A5]=8'h3C -> ready[2] in cycle t,
//    rom_address_o=1A5, rsp_valid_o=4'b0100 and rsp_data_o=3C in t+2.
//  3 All 4 requesters held valid, pointer=0 -> grants 0,1,2,3,0,... one per cycle;
//    responses in the same order, each 2 cycles after its grant, no gaps.
//  4 Requesters 1 and 3 valid, pointer=2 -> grant 3 first, then 1. Pointer becomes 0 then 2.
//  5 pause_i=1 for 3 cycles mid-stream -> no grants, enable low, the 2 in-flight responses
//    still strobe, and round-robin resumes from the saved pointer.
//  6 Assert reset_n_i low one cycle after a grant -> that response never strobes; after
//    release the pointer is 0 and normal operation resumes.

Source files
------------

// File: rtl/decoder_rom_pkg.sv
// Shared constants for the decoder ROM and its requester arbiter.
package decoder_rom_pkg;

    localparam int DECODER_ROM_ADDR_W  = 9;
    localparam int DECODER_ROM_DATA_W  = 8;
    localparam int DECODER_ROM_LATENCY = 1;

    // ROM read latency plus the response data register.
    localparam int DECODER_ROM_RSP_LATENCY = DECODER_ROM_LATENCY + 1;

endpackage

// File: rtl/decoder_rom_arbiter_rr_arbiter.sv
// Combinational round-robin core: first request at or after the pointer wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] next_ptr_o
);

    always_comb begin
        int   idx;
        logic found;
        grant_o    = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        idx        = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                // Wrap explicitly so unused pointer codes are never produced.
                next_ptr_o   = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/decoder_rom_arbiter.sv
// Shares one synchronous decoder ROM between several requesters, round-robin,
// returning data two cycles after each grant with a one-hot response strobe.
module decoder_rom_arbiter
    import decoder_rom_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ADDR_W     = DECODER_ROM_ADDR_W,
    parameter int DATA_W     = DECODER_ROM_DATA_W
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         pause_i,
    input  logic [REQUESTERS-1:0]        req_valid_i,
    input  logic [REQUESTERS*ADDR_W-1:0] req_addr_i,
    output logic [REQUESTERS-1:0]        req_ready_o,
    output logic [REQUESTERS-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic                         rom_clock_enable_o,
    output logic [ADDR_W-1:0]            rom_address_o,
    input  logic [DATA_W-1:0]            rom_data_i
);

    localparam int PW = $clog2(REQUESTERS);

    logic [PW-1:0]         ptr_q, ptr_d, next_ptr;
    logic [REQUESTERS-1:0] req_eff, grant;
    logic [REQUESTERS-1:0] tag1_q, tag1_d;
    logic [REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]     rom_addr;

    // Reset also blanks the grant so the ROM is never enabled during reset.
    assign req_eff = (reset_n_i && !pause_i) ? req_valid_i : '0;

    rr_arbiter #(
        .N  (REQUESTERS),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i      (req_eff),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .next_ptr_o (next_ptr)
    );

    always_comb begin
        rom_addr = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (grant[k]) rom_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        ptr_d       = (|grant) ? next_ptr : ptr_q;
        tag1_d      = grant;
        rsp_valid_d = tag1_q;
        rsp_data_d  = (|tag1_q) ? rom_data_i : rsp_data_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q       <= '0;
            tag1_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag1_q      <= tag1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_o        = grant;
    assign rom_clock_enable_o = |grant;
    assign rom_address_o      = rom_addr;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_data_o         = rsp_data_q;

endmodule

// File: tb/tb_decoder_rom_arbiter.sv
// Bench for decoder_rom_arbiter: grant table plus response scoreboard.
module tb_decoder_rom_arbiter;
    import decoder_rom_pkg::*;

    localparam int N  = 4;
    localparam int AW = DECODER_ROM_ADDR_W;
    localparam int DW = DECODER_ROM_DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pause = 1'b0;
    logic [N-1:0]  valid = '0;
    logic [N*AW-1:0] addr_bus;
    logic [N-1:0]  ready, rsp_valid;
    logic [DW-1:0] rsp_data, rom_q;
    logic          rom_en;
    logic [AW-1:0] rom_addr;

    logic [DW-1:0] mem [0:511];
    logic [AW-1:0] addr [N];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    assign addr_bus = {addr[3], addr[2], addr[1], addr[0]};

    decoder_rom_arbiter #(
        .REQUESTERS (N),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clock_i            (clk),
        .reset_n_i          (rst_n),
        .pause_i            (pause),
        .req_valid_i        (valid),
        .req_addr_i         (addr_bus),
        .req_ready_o        (ready),
        .rsp_valid_o        (rsp_valid),
        .rsp_data_o         (rsp_data),
        .rom_clock_enable_o (rom_en),
        .rom_address_o      (rom_addr),
        .rom_data_i         (rom_q)
    );

    // Synchronous ROM model, one-cycle latency, holds when disabled.
    always @(posedge clk) if (rom_en) rom_q <= mem[rom_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    typedef struct {
        int            k;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];

    always @(negedge rst_n) q.delete();

    // Scoreboard: push on grant, pop and compare on response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
            if (ready != '0) begin
                chk("onehot_grant", 32'($onehot(ready)), 32'h1);
                chk("rom_en", 32'(rom_en), 32'h1);
                for (int k = 0; k < N; k++) begin
                    if (ready[k]) begin
                        chk("rom_addr", 32'(rom_addr), 32'(addr[k]));
                        e.k = k;
                        e.data = mem[addr[k]];
                        e.due = cyc + 2;
                        q.push_back(e);
                    end
                end
            end else begin
                chk("rom_en_idle", 32'(rom_en), 32'h0);
                chk("rom_addr_idle", 32'(rom_addr), 32'h0);
            end
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.k));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_latency", 32'(cyc), 32'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.k));
            end
        end
    end

    typedef struct {
        logic [N-1:0] valid;
        logic         pause;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [N-1:0] vl, logic p, logic [N-1:0] r);
        vec_t t;
        t.valid = vl;
        t.pause = p;
        t.exp_ready = r;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
        mem[9'h1A5] = 8'h3C;
        addr[0] = 9'h010;
        addr[1] = 9'h0F3;
        addr[2] = 9'h1A5;
        addr[3] = 9'h17E;

        // single read by requester 2, then idle (pointer 0 -> 3)
        tbl.push_back(v(4'b0100, 0, 4'b0100));
        for (int i = 0; i < 3; i++) tbl.push_back(v(4'b0000, 0, 4'b0000));
        // requester 3 alone brings pointer back to 0
        tbl.push_back(v(4'b1000, 0, 4'b1000));
        // all valid: 0,1,2,3,0,1 back to back (pointer ends at 2)
        tbl.push_back(v(4'b1111, 0, 4'b0001));
        tbl.push_back(v(4'b1111, 0, 4'b0010));
        tbl.push_back(v(4'b1111, 0, 4'b0100));
        tbl.push_back(v(4'b1111, 0, 4'b1000));
        tbl.push_back(v(4'b1111, 0, 4'b0001));
        tbl.push_back(v(4'b1111, 0, 4'b0010));
        // requesters 1 and 3 with pointer 2: 3 first, then 1, then 3
        tbl.push_back(v(4'b1010, 0, 4'b1000));
        tbl.push_back(v(4'b1010, 0, 4'b0010));
        tbl.push_back(v(4'b1010, 0, 4'b1000));
        // pause mid-stream with two reads in flight
        tbl.push_back(v(4'b1111, 0, 4'b0001));
        tbl.push_back(v(4'b1111, 0, 4'b0010));
        tbl.push_back(v(4'b1111, 1, 4'b0000));
        tbl.push_back(v(4'b1111, 1, 4'b0000));
        tbl.push_back(v(4'b1111, 1, 4'b0000));
        tbl.push_back(v(4'b1111, 0, 4'b0100));
        tbl.push_back(v(4'b1111, 0, 4'b1000));
        tbl.push_back(v(4'b1111, 0, 4'b0001));
        for (int i = 0; i < 3; i++) tbl.push_back(v(4'b0000, 0, 4'b0000));

        // reset held with every requester valid
        rst_n = 1'b0;
        valid = '1;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rom_en", 32'(rom_en), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = '0;

        foreach (tbl[i]) begin
            valid = tbl[i].valid;
            pause = tbl[i].pause;
            @(negedge clk);
            chk($sformatf("grant[%0d]", i), 32'(ready), 32'(tbl[i].exp_ready));
            chk($sformatf("enable[%0d]", i), 32'(rom_en), 32'(|tbl[i].exp_ready));
            @(posedge clk);
            #1;
        end
        pause = 1'b0;

        // reset pulse one cycle after a grant: that response must never strobe
        valid = 4'b0001;
        @(negedge clk);
        chk("mid_grant", 32'(ready), 32'h1);
        @(posedge clk);
        #1;
        valid = '0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", 32'(rsp_data), 32'h0);
        chk("mid_rst_ready", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        valid = '1;
        @(negedge clk);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ptr0", 32'(ready), 32'h1);
        @(posedge clk);
        #1;
        valid = '0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
